// File: rtl/unpack_pkt_arbiter.sv
// unpack_pkt_arbiter
//   Packet-level round-robin arbiter sharing one downstream unpacker between
//   N_SRC packetised sources. A grant is taken on a sop beat and held until
//   the eop beat is accepted, so packets never interleave. Arbitration costs
//   one bubble cycle per packet. Streaming while locked is zero-latency.
//
//   Optional feature macro: PKT_ARB_WDOG_EN
//     Adds a stall watchdog. If the locked source stops presenting beats for
//     WDOG_CYCLES cycles while the unpacker is ready, the lock is released
//     (no eop is synthesised) and abort_pulse fires. Without the macro
//     abort_pulse is tied low and a locked source may stall forever.
//
// Parameters
//   N_SRC        number of sources (1..16)
//   DW           beat data width
//   WDOG_CYCLES  watchdog stall limit (watchdog builds only)
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   s_valid/s_ready   per-source handshake
//   s_data            source i occupies s_data[i*DW +: DW]
//   s_sop/s_eop       per-source packet delimiters
//   m_valid/m_ready   handshake toward the unpacker
//   m_data/m_sop/m_eop muxed beat from the locked source
//   grant_idx         locked source index, held after the lock ends
//   busy              high while a packet is locked
//   drop_pulse        one cycle: a stray non-sop beat was discarded while idle
//   abort_pulse       one cycle: the watchdog released a lock
module unpack_pkt_arbiter #(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned DW          = 32,
  parameter int unsigned WDOG_CYCLES = 64,
  localparam int unsigned IW         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    s_valid,
  output logic [N_SRC-1:0]    s_ready,
  input  logic [N_SRC*DW-1:0] s_data,
  input  logic [N_SRC-1:0]    s_sop,
  input  logic [N_SRC-1:0]    s_eop,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DW-1:0]       m_data,
  output logic                m_sop,
  output logic                m_eop,
  output logic [IW-1:0]       grant_idx,
  output logic                busy,
  output logic                drop_pulse,
  output logic                abort_pulse
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]       state;
  logic [IW-1:0]    rr_ptr;

  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] stray;
  logic             win_found;
  logic             hi_found;
  logic [IW-1:0]    hi_idx;
  logic [IW-1:0]    lo_idx;
  logic [IW-1:0]    win_idx;

  logic             g_valid;
  logic             g_sop;
  logic             g_eop;
  logic [DW-1:0]    g_data;
  logic             g_accept;
  logic             g_done;
  logic [IW-1:0]    g_next;
  logic             wdog_fire;

  assign cand  = s_valid & s_sop;
  assign stray = s_valid & ~s_sop;

  // Round-robin pick: lowest candidate at or above rr_ptr, otherwise the
  // lowest candidate overall (the wrap-around case).
  always_comb begin
    hi_found = 1'b0;
    win_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (cand[i] && !win_found) begin
        win_found = 1'b1;
        lo_idx    = IW'(i);
      end
      if (cand[i] && !hi_found && (IW'(i) >= rr_ptr)) begin
        hi_found = 1'b1;
        hi_idx   = IW'(i);
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  // Locked-source mux
  always_comb begin
    g_valid = 1'b0;
    g_sop   = 1'b0;
    g_eop   = 1'b0;
    g_data  = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (grant_idx == IW'(i)) begin
        g_valid = s_valid[i];
        g_sop   = s_sop[i];
        g_eop   = s_eop[i];
        g_data  = s_data[i*DW +: DW];
      end
    end
  end

  assign busy     = (state == LOCK);
  assign m_valid  = busy & g_valid;
  assign m_sop    = busy & g_sop;
  assign m_eop    = busy & g_eop;
  assign m_data   = busy ? g_data : '0;
  assign g_accept = busy & g_valid & m_ready;
  assign g_done   = g_accept & g_eop;
  assign g_next   = (grant_idx == IW'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;

  // While idle, stray non-sop beats are swallowed; sop beats wait for the
  // lock. Ready is forced low during reset so nothing is consumed then.
  always_comb begin
    s_ready = '0;
    if (!rst) begin
      if (state == IDLE) begin
        s_ready = stray;
      end else begin
        for (int unsigned i = 0; i < N_SRC; i++) begin
          if (grant_idx == IW'(i)) s_ready[i] = m_ready;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_idx  <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= (state == IDLE) && (|stray);
      if (state == IDLE) begin
        if (win_found) begin
          grant_idx <= win_idx;
          state     <= LOCK;
        end
      end else begin
        if (g_done || wdog_fire) begin
          state  <= IDLE;
          rr_ptr <= g_next;
        end
      end
    end
  end

`ifdef PKT_ARB_WDOG_EN
  localparam int unsigned CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] wdog_cnt;
  logic          wdog_inc;

  assign wdog_inc  = busy & ~g_valid & m_ready;
  // Fires on the edge where the count would reach WDOG_CYCLES.
  assign wdog_fire = wdog_inc && (wdog_cnt == CW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt    <= '0;
      abort_pulse <= 1'b0;
    end else begin
      abort_pulse <= wdog_fire;
      if (!busy || g_accept || wdog_fire) begin
        wdog_cnt <= '0;
      end else if (wdog_inc) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
    end
  end
`else
  // WDOG_CYCLES only matters with the watchdog; keep it referenced so the
  // parameter list is identical across builds.
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_CYCLES;
  assign wdog_fire       = 1'b0;
  assign abort_pulse     = 1'b0;
`endif

endmodule
